// File: rtl/undo_log_writer.sv
// Undo-log writer: buffers core undo entries in a small FIFO and writes each one into its
// per-CQ-slot undo region, with a drain handshake that confirms all accepted writes are durable.
module undo_log_writer #(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned SLOT_W           = 7,
  parameter int unsigned ID_W             = 4,
  parameter int unsigned ENTRIES_PER_SLOT = 8,
  parameter logic [31:0] BASE_ADDR        = 32'h1000_0000,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              undo_log_valid,
  output logic              undo_log_ready,
  input  logic [ID_W-1:0]   undo_log_id,
  input  logic [31:0]       undo_log_addr,
  input  logic [31:0]       undo_log_data,
  input  logic [SLOT_W-1:0] undo_log_slot,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [31:0]       mem_awaddr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic              drain_valid,
  output logic              drain_done,
  output logic [31:0]       num_writes,
  output logic              overflow_err,
  output logic              bresp_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StRun, StDrainWait, StDrainAck} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]     addr_mem [FIFO_DEPTH];
  logic [63:0]     data_mem [FIFO_DEPTH];
  logic [2:0]      outst_q, outst_d;
  logic [31:0]     num_writes_q;
  logic            overflow_q, bresp_q;

  logic        fifo_empty, fifo_full, fifo_empty_d;
  logic        accept, id_ok, push, pop, b_ok;
  logic [31:0] entry_addr;

  assign fifo_empty   = (wptr_q == rptr_q);
  assign fifo_full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign accept       = undo_log_valid && undo_log_ready;
  assign id_ok        = 32'(undo_log_id) < ENTRIES_PER_SLOT;
  assign push         = accept && id_ok;
  assign pop          = mem_awvalid && mem_awready;
  assign b_ok         = mem_bvalid && (outst_q != 3'd0);
  assign wptr_d       = wptr_q + {{(PW-1){1'b0}}, push};
  assign rptr_d       = rptr_q + {{(PW-1){1'b0}}, pop};
  assign fifo_empty_d = (wptr_d == rptr_d);
  assign entry_addr   = BASE_ADDR +
                        ((32'(undo_log_slot) * ENTRIES_PER_SLOT + 32'(undo_log_id)) << 3);

  assign mem_awaddr = addr_mem[rptr_q[AW-1:0]];
  assign mem_wdata  = data_mem[rptr_q[AW-1:0]];
  assign mem_bready = 1'b1;
  assign num_writes   = num_writes_q;
  assign overflow_err = overflow_q;
  assign bresp_err    = bresp_q;

  always_comb begin
    outst_d = outst_q;
    unique case ({pop, b_ok})
      2'b10:   outst_d = outst_q + 3'd1;
      2'b01:   outst_d = outst_q - 3'd1;
      default: outst_d = outst_q;
    endcase
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q[AW-1:0]] <= entry_addr;
      data_mem[wptr_q[AW-1:0]] <= {undo_log_data, undo_log_addr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      outst_q      <= '0;
      num_writes_q <= '0;
      overflow_q   <= 1'b0;
      bresp_q      <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      outst_q      <= outst_d;
      num_writes_q <= num_writes_q + {31'd0, b_ok};
      if (accept && !id_ok) overflow_q <= 1'b1;
      if (mem_bvalid && (outst_q == 3'd0)) bresp_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // Completion uses next-state occupancy so a final bvalid can close the drain in its own cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:       if (drain_valid) state_d = StDrainWait;
      StDrainWait: if (fifo_empty_d && (outst_d == 3'd0)) state_d = StDrainAck;
      StDrainAck:  state_d = StRun;
      default:     state_d = StRun;
    endcase
  end

  always_comb begin
    undo_log_ready = !rst && (state_q == StRun) && !fifo_full;
    mem_awvalid    = !fifo_empty && (32'(outst_q) < MAX_OUTSTANDING);
    drain_done     = (state_q == StDrainAck);
  end

endmodule

// File: tb/tb_undo_log_writer.sv
// Randomized bench for undo_log_writer against a queue-based reference model.
module tb_undo_log_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned EPS   = 8;
  localparam int unsigned MAXO  = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        undo_log_valid;
  logic        undo_log_ready;
  logic [3:0]  undo_log_id;
  logic [31:0] undo_log_addr;
  logic [31:0] undo_log_data;
  logic [6:0]  undo_log_slot;
  logic        mem_awvalid;
  logic        mem_awready;
  logic [31:0] mem_awaddr;
  logic [63:0] mem_wdata;
  logic        mem_bvalid;
  logic        mem_bready;
  logic        drain_valid;
  logic        drain_done;
  logic [31:0] num_writes;
  logic        overflow_err;
  logic        bresp_err;

  undo_log_writer dut (
    .clk            (clk),
    .rst            (rst),
    .undo_log_valid (undo_log_valid),
    .undo_log_ready (undo_log_ready),
    .undo_log_id    (undo_log_id),
    .undo_log_addr  (undo_log_addr),
    .undo_log_data  (undo_log_data),
    .undo_log_slot  (undo_log_slot),
    .mem_awvalid    (mem_awvalid),
    .mem_awready    (mem_awready),
    .mem_awaddr     (mem_awaddr),
    .mem_wdata      (mem_wdata),
    .mem_bvalid     (mem_bvalid),
    .mem_bready     (mem_bready),
    .drain_valid    (drain_valid),
    .drain_done     (drain_done),
    .num_writes     (num_writes),
    .overflow_err   (overflow_err),
    .bresp_err      (bresp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
  } ent_t;

  // Model: 0 = run, 1 = waiting for drain, 2 = acknowledging drain.
  ent_t        mq[$];
  int          m_out;
  int          m_state;
  int unsigned m_nw;
  bit          m_ovf;
  bit          m_berr;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out   = 0;
    m_state = 0;
    m_nw    = 0;
    m_ovf   = 0;
    m_berr  = 0;
  endtask

  initial begin
    bit          exp_awv, ready_n, fire, acc, bok;
    int unsigned idx;
    ent_t        e;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    undo_log_valid = 1'b0;
    undo_log_id = '0;
    undo_log_addr = '0;
    undo_log_data = '0;
    undo_log_slot = '0;
    mem_awready = 1'b0;
    mem_bvalid = 1'b0;
    drain_valid = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      exp_awv = (mq.size() > 0) && (m_out < int'(MAXO));
      check("ready", 64'(undo_log_ready),
            64'(!rst && m_state == 0 && mq.size() < int'(DEPTH)));
      check("awvalid", 64'(mem_awvalid), 64'(exp_awv));
      if (exp_awv) begin
        check("awaddr", 64'(mem_awaddr), 64'(mq[0].a));
        check("wdata", mem_wdata, mq[0].d);
      end
      check("drain_done", 64'(drain_done), 64'(m_state == 2));
      check("num_writes", 64'(num_writes), 64'(m_nw));
      check("overflow_err", 64'(overflow_err), 64'(m_ovf));
      check("bresp_err", 64'(bresp_err), 64'(m_berr));

      if (drain_valid && m_state == 2 && $urandom_range(0, 1) == 1) drain_valid = 1'b0;
      else if (!drain_valid && $urandom_range(0, 49) == 0) drain_valid = 1'b1;
      rst            = ($urandom_range(0, 199) == 0);
      undo_log_valid = ($urandom_range(0, 2) != 0);
      undo_log_id    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                   : 4'($urandom_range(0, 7));
      undo_log_slot  = 7'($urandom);
      undo_log_addr  = $urandom;
      undo_log_data  = $urandom;
      mem_awready    = (cyc % 64 < 16) ? 1'b0 : ($urandom_range(0, 3) != 0);
      mem_bvalid     = (m_out > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 3);

      ready_n = !rst && m_state == 0 && mq.size() < int'(DEPTH);
      fire    = exp_awv && mem_awready;
      if (rst) begin
        model_reset();
      end else begin
        acc = undo_log_valid && ready_n;
        bok = mem_bvalid && m_out > 0;
        if (fire) void'(mq.pop_front());
        if (acc) begin
          if (int'(undo_log_id) < int'(EPS)) begin
            idx = int'(undo_log_slot) * EPS + int'(undo_log_id);
            e.a = BASE + (idx * 8);
            e.d = {undo_log_data, undo_log_addr};
            mq.push_back(e);
          end else begin
            m_ovf = 1;
          end
        end
        if (mem_bvalid && m_out == 0) m_berr = 1;
        m_out = m_out + int'(fire) - int'(bok);
        m_nw  = m_nw + int'(bok);
        case (m_state)
          0:       if (drain_valid) m_state = 1;
          1:       if (mq.size() == 0 && m_out == 0) m_state = 2;
          default: m_state = 0;
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
